// File: rtl/cache_miss_ctrl_pkg.sv
// cache_miss_ctrl_pkg: shared states, geometry defaults and way helper for the miss controller.
package cache_miss_ctrl_pkg;
  localparam int LINE_WORDS_DEF = 16;
  localparam int TAG_W_DEF = 20;
  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_WB, S_RDREQ, S_RDDATA, S_FILL, S_DONE
  } state_e;
  function automatic logic [3:0] fix_way(input logic [3:0] w);
    return (w != 4'b0 && (w & (w - 4'd1)) == 4'b0) ? w : 4'b0001;
  endfunction
endpackage

// File: rtl/cache_miss_ctrl_refill_buf.sv
// refill_buf: refill line buffer written one word per beat, with a saturating word counter.
module refill_buf
  import cache_miss_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [31:0]              wdata,
  output logic [32*LINE_WORDS-1:0] line
);
  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32*LINE_WORDS-1:0] line_q, line_d;
  always_comb begin
    line_d = clr ? '0 : line_q;
    cnt_d = clr ? '0 : cnt_q;
    if (we) begin
      line_d[32*cnt_q +: 32] = wdata;
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      line_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      line_q <= line_d;
    end
  end
  assign line = line_q;
endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: resolves a cache miss by optional victim writeback, line refill, array fill and LRU update.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [31:0]              miss_addr,
  input  logic [3:0]               way_sel,
  input  logic [3:0]               victim_dirty,
  input  logic [TAG_W-1:0]         victim_tag,
  input  logic [32*LINE_WORDS-1:0] victim_line,
  output logic                     lru_en,
  output logic [3:0]               lru_visit,
  output logic                     wr_req,
  output logic [31:0]              wr_addr,
  output logic [32*LINE_WORDS-1:0] wr_data,
  input  logic                     wr_rdy,
  output logic                     rd_req,
  output logic [31:0]              rd_addr,
  input  logic                     rd_rdy,
  input  logic                     ret_valid,
  input  logic                     ret_last,
  input  logic [31:0]              ret_data,
  output logic [3:0]               fill_we,
  output logic [5:0]               fill_index,
  output logic [TAG_W-1:0]         fill_tag,
  output logic [32*LINE_WORDS-1:0] fill_data,
  output logic                     done
);
  localparam int LW = 32 * LINE_WORDS;
  state_e state_q, state_d;
  logic [31:6] addr_q, addr_d;
  logic [3:0] way_q, way_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [LW-1:0] line_q, line_d;
  logic [LW-1:0] buf_line;
  logic unused_ok;
  assign unused_ok = ^miss_addr[5:0];
  // The buffer is cleared on acceptance so short refills leave the tail words zero.
  refill_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == S_IDLE && miss_valid),
    .we   (state_q == S_RDDATA && ret_valid),
    .wdata(ret_data),
    .line (buf_line)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    way_d = way_q;
    tag_d = tag_q;
    line_d = line_q;
    case (state_q)
      S_IDLE: if (miss_valid) begin
        addr_d = miss_addr[31:6];
        state_d = S_SEL;
      end
      S_SEL: begin
        way_d = fix_way(way_sel);
        tag_d = victim_tag;
        line_d = victim_line;
        state_d = |(victim_dirty & fix_way(way_sel)) ? S_WB : S_RDREQ;
      end
      S_WB: state_d = wr_rdy ? S_RDREQ : S_WB;
      S_RDREQ: state_d = rd_rdy ? S_RDDATA : S_RDREQ;
      S_RDDATA: state_d = (ret_valid && ret_last) ? S_FILL : S_RDDATA;
      S_FILL: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    miss_ready = state_q == S_IDLE;
    wr_req = state_q == S_WB;
    wr_addr = wr_req ? {tag_q, addr_q[31-TAG_W:6], 6'b0} : 32'b0;
    wr_data = wr_req ? line_q : '0;
    rd_req = state_q == S_RDREQ;
    rd_addr = rd_req ? {addr_q, 6'b0} : 32'b0;
    lru_en = state_q == S_FILL;
    lru_visit = lru_en ? way_q : 4'b0;
    fill_we = lru_en ? way_q : 4'b0;
    fill_index = lru_en ? addr_q[11:6] : 6'b0;
    fill_tag = lru_en ? addr_q[31 -: TAG_W] : '0;
    fill_data = lru_en ? buf_line : '0;
    done = state_q == S_DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      way_q <= '0;
      tag_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      way_q <= way_d;
      tag_q <= tag_d;
      line_q <= line_d;
    end
  end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: table-driven and randomized checks of cache_miss_ctrl against a line-level reference model.
module tb_cache_miss_ctrl;
  logic clk = 0, rst = 1;
  logic miss_valid = 0, miss_ready;
  logic [31:0] miss_addr = 0;
  logic [3:0] way_sel = 0, victim_dirty = 0;
  logic [19:0] victim_tag = 0;
  logic [511:0] victim_line = 0;
  logic lru_en, wr_req, wr_rdy = 0, rd_req, rd_rdy = 0, ret_valid = 0, ret_last = 0, done;
  logic [3:0] lru_visit, fill_we;
  logic [31:0] wr_addr, rd_addr, ret_data = 0;
  logic [511:0] wr_data, fill_data;
  logic [5:0] fill_index;
  logic [19:0] fill_tag;
  int errs = 0, checks = 0, cyc = 0;
  logic [31:0] bd [32];
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  way;
    logic [3:0]  dirty;
    logic [19:0] tag;
    int          nb, wbs, rds, gaps;
    logic [3:0]  e_way;
    logic        e_wb;
    logic [31:0] e_wa, e_ra;
    logic [5:0]  e_idx;
    logic [19:0] e_tag;
  } vec_t;
  vec_t tv [6];
  cache_miss_ctrl dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .way_sel(way_sel), .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .lru_en(lru_en), .lru_visit(lru_visit), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_last(ret_last), .ret_data(ret_data), .fill_we(fill_we), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_data(fill_data), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] addr, input logic [3:0] way, input logic [3:0] dirty,
                     input logic [19:0] tag, input int nb, input int wbs, input int rds, input int gaps,
                     input logic [3:0] e_way, input logic e_wb, input logic [31:0] e_wa,
                     input logic [31:0] e_ra, input logic [5:0] e_idx, input logic [19:0] e_tag);
    logic [511:0] vl, el;
    int c0, extra;
    logic ok;
    for (int i = 0; i < 16; i++) vl[i*32 +: 32] = $urandom;
    for (int i = 0; i < 32; i++) bd[i] = $urandom;
    el = '0;
    for (int i = 0; i < nb; i++) el[(i < 16 ? i : 15)*32 +: 32] = bd[i];
    chk("idle_ready", miss_ready, 1);
    miss_valid = 1; miss_addr = addr; way_sel = way; victim_dirty = dirty; victim_tag = tag; victim_line = vl;
    step();
    c0 = cyc;
    miss_valid = 0; miss_addr = $urandom;
    chk("sel_ready", miss_ready, 0);
    step();
    way_sel = 4'($urandom); victim_dirty = 4'($urandom); victim_tag = 20'($urandom); victim_line = '0;
    extra = rds + gaps;
    chk("wr_req", wr_req, e_wb);
    if (e_wb) begin
      ok = 1;
      repeat (wbs) begin
        ok &= wr_req & ~rd_req;
        step();
      end
      chk("wb_hold", ok & wr_req, 1);
      chk("wr_addr", wr_addr, e_wa);
      chk("wr_data", wr_data, vl);
      chk("wb_no_rd", rd_req, 0);
      wr_rdy = 1;
      step();
      wr_rdy = 0;
      extra += wbs + 1;
      chk("wb_drop", wr_req, 0);
    end
    ok = 1;
    repeat (rds) begin
      ok &= rd_req;
      step();
    end
    chk("rd_req", ok & rd_req, 1);
    chk("rd_addr", rd_addr, e_ra);
    rd_rdy = 1;
    step();
    rd_rdy = 0;
    chk("rd_drop", rd_req, 0);
    step();
    ok = 1;
    for (int i = 0; i < nb; i++) begin
      if (i == nb / 2) repeat (gaps) begin
        ret_valid = 0;
        ok &= (fill_we == 0) & ~lru_en & ~done;
        step();
      end
      ok &= (fill_we == 0) & ~lru_en & ~done;
      ret_valid = 1; ret_data = bd[i]; ret_last = (i == nb - 1);
      step();
    end
    ret_valid = 0; ret_last = 0; ret_data = $urandom;
    chk("no_early_fill", ok, 1);
    chk("fill_we", fill_we, e_way);
    chk("lru", {lru_en, lru_visit}, {1'b1, e_way});
    chk("fill_index", fill_index, e_idx);
    chk("fill_tag", fill_tag, e_tag);
    chk("fill_data", fill_data, el);
    chk("fill_no_done", done, 0);
    step();
    chk("done", done, 1);
    chk("done_quiet", {fill_we, lru_en, miss_ready, rd_req, wr_req}, 0);
    chk("latency", cyc - c0, 4 + nb + extra);
    miss_valid = 1; miss_addr = $urandom;
    step();
    miss_valid = 0;
    chk("done_no_accept", {miss_ready, done}, 2'b10);
  endtask

  initial begin
    logic ok;
    logic [31:0] a;
    logic [3:0] w, d, fw;
    logic [19:0] t;
    tv[0] = '{32'h0000_1A40, 4'b0010, 4'b0000, 20'h12345, 16, 0, 0, 0, 4'b0010, 1'b0, 32'h1234_5A40, 32'h0000_1A40, 6'h29, 20'h00001};
    tv[1] = '{32'h0000_1A40, 4'b1000, 4'b1000, 20'hABCDE, 16, 5, 0, 0, 4'b1000, 1'b1, 32'hABCD_EA40, 32'h0000_1A40, 6'h29, 20'h00001};
    tv[2] = '{32'h1234_5680, 4'b0100, 4'b0011, 20'h00000, 4, 0, 1, 0, 4'b0100, 1'b0, 32'h0000_0680, 32'h1234_5680, 6'h1A, 20'h12345};
    tv[3] = '{32'hFFFF_FFFC, 4'b0001, 4'b1110, 20'h55555, 20, 0, 0, 2, 4'b0001, 1'b0, 32'h5555_5FC0, 32'hFFFF_FFC0, 6'h3F, 20'hFFFFF};
    tv[4] = '{32'h0000_0040, 4'b0110, 4'b0000, 20'h00000, 8, 0, 2, 0, 4'b0001, 1'b0, 32'h0000_0040, 32'h0000_0040, 6'h01, 20'h00000};
    tv[5] = '{32'h8000_0FC0, 4'b0000, 4'b0001, 20'h00F0F, 1, 2, 0, 0, 4'b0001, 1'b1, 32'h00F0_FFC0, 32'h8000_0FC0, 6'h3F, 20'h80000};
    #12;
    chk("reset_ready", miss_ready, 1);
    chk("reset_ctl", {wr_req, rd_req, fill_we, lru_en, lru_visit, done, fill_index}, 0);
    chk("reset_bus", {wr_addr, rd_addr, fill_tag}, 0);
    chk("reset_data", wr_data | fill_data, 0);
    step();
    rst = 0;
    for (int k = 0; k < 6; k++)
      run(tv[k].addr, tv[k].way, tv[k].dirty, tv[k].tag, tv[k].nb, tv[k].wbs, tv[k].rds, tv[k].gaps,
          tv[k].e_way, tv[k].e_wb, tv[k].e_wa, tv[k].e_ra, tv[k].e_idx, tv[k].e_tag);
    miss_addr = 32'h0000_2000; way_sel = 4'b0001; victim_dirty = 0; miss_valid = 1;
    step();
    miss_valid = 0;
    step();
    rd_rdy = 1;
    step();
    rd_rdy = 0;
    repeat (3) begin
      ret_valid = 1; ret_data = $urandom;
      step();
    end
    #3 rst = 1;
    #1;
    chk("rst_async_ready", miss_ready, 1);
    chk("rst_async_outs", {rd_req, wr_req, fill_we, lru_en, done}, 0);
    ret_last = 1;
    ok = 1;
    repeat (3) begin
      step();
      ok &= (fill_we == 0) & ~lru_en & ~done & miss_ready;
    end
    rst = 0; ret_valid = 0; ret_last = 0;
    repeat (3) begin
      step();
      ok &= (fill_we == 0) & ~lru_en & ~done & miss_ready;
    end
    chk("rst_no_fill", ok, 1);
    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      w = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      d = 4'($urandom);
      t = 20'($urandom);
      fw = ($countones(w) == 1) ? w : 4'b0001;
      run(a, w, d, t, $urandom_range(1, 20), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
          fw, |(d & fw), {t, a[11:6], 6'b0}, {a[31:6], 6'b0}, a[11:6], a[31:12]);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16, meaning 32-bit words per cache line (64-byte line).
REQ-002 SHALL have parameter TAG_W, default 20, meaning tag width (addr[31:12]).
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports miss_valid (input, 1), miss_ready (output, 1) and miss_addr (input, 32): the miss request handshake.
REQ-006 SHALL have port way_sel, input, 4: one-hot victim way from the LRU replacement unit for index miss_addr[11:6].
REQ-007 SHALL have ports victim_dirty (input, 4), victim_tag (input, TAG_W) and victim_line (input, 32*LINE_WORDS): the selected way's state, valid in S_SEL.
REQ-008 SHALL have ports lru_en (output, 1) and lru_visit (output, 4): the replacement-state update strobe and the one-hot way to promote.
REQ-009 SHALL have ports wr_req (output, 1), wr_addr (output, 32), wr_data (output, 32*LINE_WORDS) and wr_rdy (input, 1): the writeback handshake.
REQ-010 SHALL have ports rd_req (output, 1), rd_addr (output, 32) and rd_rdy (input, 1): the refill request handshake.
REQ-011 SHALL have ports ret_valid (input, 1), ret_last (input, 1) and ret_data (input, 32): the refill return beats.
REQ-012 SHALL have ports fill_we (output, 4), fill_index (output, 6), fill_tag (output, TAG_W) and fill_data (output, 32*LINE_WORDS): the cache array write.
REQ-013 SHALL have port done, output, 1: a one-cycle pulse when the miss is resolved.

Function
REQ-014 SHALL implement FSM states S_IDLE, S_SEL, S_WB, S_RDREQ, S_RDDATA, S_FILL, S_DONE.
REQ-015 S_IDLE: miss_ready=1; when miss_valid=1, SHALL latch miss_addr and go to S_SEL; miss_ready SHALL be 0 in every other state.
REQ-016 S_SEL (1 cycle): SHALL latch way_sel, victim_tag and victim_line; if victim_dirty & way_sel is nonzero, go to S_WB, else go to S_RDREQ.
REQ-017 If the latched way_sel is not one-hot, SHALL substitute 4'b0001.
REQ-018 S_WB: wr_req=1, wr_addr={victim_tag, index, 6'b0}, wr_data=latched line; SHALL go to S_RDREQ in the cycle after wr_req&&wr_rdy.
REQ-019 S_RDREQ: rd_req=1, rd_addr={addr[31:6], 6'b0}; SHALL go to S_RDDATA after rd_req&&rd_rdy.
REQ-020 S_RDDATA: each ret_valid beat SHALL write ret_data into buffer word cnt, then cnt increments (4-bit counter, starts at 0).
REQ-021 S_RDDATA: ret_valid&&ret_last SHALL go to S_FILL regardless of cnt; words not received SHALL be 0.
REQ-022 S_RDDATA: beats arriving when cnt==LINE_WORDS-1 with ret_last=0 SHALL be written and cnt SHALL saturate; no wrap-around overwrite of word 0.
REQ-023 S_FILL (1 cycle): fill_we=latched way, fill_index=addr[11:6], fill_tag=addr[31:12], fill_data=buffer; lru_en=1, lru_visit=latched way.
REQ-024 S_DONE (1 cycle): done=1, then S_IDLE; a miss_valid in this cycle SHALL NOT be accepted.
REQ-025 fill_we, lru_en, wr_req, rd_req and done SHALL be 0 outside their states.
REQ-026 Minimum latency, clean miss with rd_rdy=1 and one-cycle return: accept edge to done = 4 + number of beats cycles.

Reset
REQ-027 rst=1 SHALL asynchronously force S_IDLE, cnt=0 and buffer=0; miss_ready=1 and all other outputs 0.
REQ-028 Reset mid-transaction SHALL abandon it with no fill_we or lru_en pulse.

Structure
REQ-029 State encodings, LINE_WORDS and TAG_W defaults SHALL live in a shared cache package.
REQ-030 The refill word buffer and its counter SHALL be one sub-module, refill_buf.

Verification
REQ-031 Clean miss, addr 0x0000_1A40, way_sel=0010, dirty=0 -> rd_addr 0x0000_1A40, no wr_req; after 16 beats, fill_we=0010, fill_index=0x29, lru_visit=0010, done.
REQ-032 Dirty victim, way_sel=1000, dirty=1000, victim_tag=0xABCDE -> wr_addr 0xABCD_EA40 before rd_req; wr_rdy held low 5 cycles keeps wr_req=1.
REQ-033 ret_last on beat 4 -> fill_data words 4..15 = 0, fill on the next cycle.
REQ-034 20 beats without ret_last -> word 15 = beat 20 data, word 0 unchanged, cnt stays 15.
REQ-035 rst asserted in S_RDDATA -> outputs 0 immediately, miss_ready=1, no fill_we or lru_en pulse.
REQ-036 way_sel=0110 -> way 0001 is used for fill_we and lru_visit.
